// File: rtl/cnn_seq_pkg.sv
// Shared types and helpers for the CNN layer sequencer.
// Optional feature macro used by the sequencer: CNN_SEQ_WATCHDOG_EN.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } seq_state_e;

  // Layer index width; a single layer still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_seq_next_sel.sv
// Priority selector: lowest non-skipped layer, either from index 0 or strictly
// above a threshold index.
module cnn_seq_next_sel #(
  parameter int NUM_LAYERS = 3,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_LAYERS-1:0] mask_i,
  input  logic [IDX_W-1:0]      thresh_i,
  input  logic                  from_start_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  found_o
);

  // Scan downwards so the lowest eligible index is the one left standing.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (!mask_i[k] && (from_start_i || (k > int'(thresh_i)))) begin
        idx_o   = IDX_W'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs NUM_LAYERS layer engines in order through start/done handshakes with a
// per-run skip mask and abort. Watchdog compiled in with CNN_SEQ_WATCHDOG_EN.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter  int NUM_LAYERS     = 3,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 65536,
  localparam int IDX_W          = idx_width(NUM_LAYERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_LAYERS-1:0]    skip_mask,
  output logic [NUM_LAYERS-1:0]    layer_start,
  input  logic [NUM_LAYERS-1:0]    layer_done,
  input  logic signed [DATA_W-1:0] result_in,
  output logic signed [DATA_W-1:0] value,
  output logic                     done,
  output logic                     busy,
  output logic [IDX_W-1:0]         layer_idx,
  output logic                     error,
  output logic [2:0]               dbg_state
);

  if (NUM_LAYERS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cnn_layer_sequencer: NUM_LAYERS and TIMEOUT_CYCLES must be >= 1");
  end

  seq_state_e               state_q, state_d;
  logic [NUM_LAYERS-1:0]    mask_q, mask_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] value_q, value_d;
  logic [NUM_LAYERS-1:0]    layer_start_q, layer_start_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic                     launch_st;
  logic [NUM_LAYERS-1:0]    sel_mask;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_found;

`ifdef CNN_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
`endif

  // At launch the live skip_mask is searched from index 0; in WAIT the latched
  // mask is searched strictly above the active layer.
  assign launch_st = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign sel_mask  = launch_st ? skip_mask : mask_q;

  cnn_seq_next_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_next_sel (
    .mask_i       (sel_mask),
    .thresh_i     (idx_q),
    .from_start_i (launch_st),
    .idx_o        (sel_idx),
    .found_o      (sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      value_q       <= '0;
      layer_start_q <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
`ifdef CNN_SEQ_WATCHDOG_EN
      wd_q          <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      value_q       <= value_d;
      layer_start_q <= layer_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
`ifdef CNN_SEQ_WATCHDOG_EN
      wd_q          <= wd_d;
      error_q       <= error_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    value_d = value_q;
`ifdef CNN_SEQ_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            mask_d = skip_mask;
            if (sel_found) begin
              idx_d   = sel_idx;
              state_d = S_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
`ifdef CNN_SEQ_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
        S_WAIT: begin
          if (layer_done[idx_q]) begin
            if (sel_found) begin
              idx_d   = sel_idx;
              state_d = S_ISSUE;
            end else begin
              value_d = result_in;
              state_d = S_DONE;
            end
          end
`ifdef CNN_SEQ_WATCHDOG_EN
          else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
            state_d = S_ERR;
          end else begin
            wd_d = wd_q + 1'b1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_comb begin
    layer_start_d = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      layer_start_d[k] = (state_d == S_ISSUE) && (idx_d == IDX_W'(k));
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
`ifdef CNN_SEQ_WATCHDOG_EN
    error_d = (state_d == S_ERR);
`endif
  end

  assign layer_start = layer_start_q;
  assign value       = value_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign layer_idx   = idx_q;
  assign dbg_state   = state_q;
`ifdef CNN_SEQ_WATCHDOG_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Parametrised controller that runs a chain of `NUM_LAYERS` compute layers (conv, pool, fc, ...) in a fixed order through per-layer start/done handshakes. It also captures the final layer's result and reports completion. It sits above the layer engines in the CNN core and replaces a hard-wired three-layer FSM. Over that FSM it adds:
- a per-run layer skip mask
- an abort
- re-launch from the done state
- a compile-time per-layer watchdog

## Interface
Parameters:
- `NUM_LAYERS`, 3: number of chained layers; must be ≥1.
- `DATA_W`, 32: width of result path.
- `TIMEOUT_CYCLES`, 65536: watchdog limit, counted in WAIT cycles per layer. Only used with the watchdog compiled in.
- `IDX_W`, `$clog2(NUM_LAYERS)` with a minimum of 1: derived localparam.

Ports:
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch request; sampled in IDLE, DONE and ERR.
- `abort`  in  1: return to IDLE from any state.
- `skip_mask`  in  NUM_LAYERS: bit k=1 means layer k is skipped; latched when `start` is accepted.
- `layer_start`  out  NUM_LAYERS: one-hot, one-cycle start pulse to each layer.
- `layer_done`  in  NUM_LAYERS: per-layer completion pulse or level.
- `result_in`  in  DATA_W signed: output of the last layer.
- `value`  out  DATA_W signed: captured result.
- `done`  out  1: run complete; held high until the next `start` or `abort`.
- `busy`  out  1: high in ISSUE and WAIT.
- `layer_idx`  out  IDX_W: index of the active or last-issued layer.
- `error`  out  1: watchdog expired; tied 0 without the watchdog.

## Operation
- States:
  - IDLE, ISSUE, WAIT, DONE, ERR.
  - Reset enters IDLE.
  - All outputs are registered and reset to 0.
- IDLE / DONE / ERR with `start`=1:
  - Latch `skip_mask`, clear `done`/`error`.
  - Select the lowest non-skipped index.
  - If every layer is skipped, go to DONE, leave `value` unchanged and set `done`=1.
  - Otherwise load `layer_idx` and go to ISSUE.
- ISSUE:
  - `layer_start[layer_idx]`=1 for exactly this cycle; all other bits are 0.
  - Unconditionally go to WAIT.
  - Clear the watchdog counter.
- WAIT:
  - Only `layer_done[layer_idx]` is observed. Other `done` bits are ignored.
  - When it is seen and a higher non-skipped index exists, load that index and go to ISSUE.
  - When it is seen and no higher non-skipped index exists, capture `result_in` into `value`, set `done`=1 and go to DONE.
- `abort`=1:
  - In any state, go to IDLE on the next cycle.
  - Clear `layer_start`, `done`, `error`, `busy`.
  - `value` and `layer_idx` hold.
- Priority, highest first: `rst` > `abort` > `start` > `layer_done`.
- `start` while `busy` is ignored.
- `layer_done` asserted during ISSUE is ignored. A level-style `done` still high in WAIT is accepted.

## Timing
- `start` sampled at cycle 0 → `layer_start[first]` high in cycle 1, WAIT from cycle 2.
- `layer_done[k]` sampled in WAIT at cycle t → next `layer_start` high at t+1.
  - If k is the last non-skipped layer, `done`=1 and `value` is valid at t+1.
- Sequencer overhead per layer: 1 ISSUE cycle plus 1 cycle from `done` to the next action.
- All layers skipped: `done`=1 at cycle 1.
- Abort accepted at cycle t → IDLE and all strobes low at t+1.

## Configuration
- `CNN_SEQ_WATCHDOG_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` increments every WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` without the active `layer_done`, go to ERR on the next cycle.
  - `error`=1 and `layer_idx` keeps the failing layer.
  - ERR is left only by `start` (re-run), `abort` or `rst`.
- `CNN_SEQ_WATCHDOG_EN` undefined:
  - No counter and no ERR state logic; `error` is tied to 0.
  - WAIT persists until the active layer signals done.

## Structure
- Package `cnn_seq_pkg`:
  - State enum.
  - A helper function for the index width.
- Sub-module `cnn_seq_next_sel`:
  - Combinational priority selector.
  - Inputs: the latched mask and a "strictly above index" threshold with a "from-start" flag.
  - Outputs: next index and a `found` flag.
  - Used both at launch and at each layer completion.

## Test plan
1. NUM_LAYERS=3, mask 3'b000, `start` at cycle 0, each layer's `done` 5/7/3 cycles after its `start`, `result_in`=32'sd-42 → `layer_start` pulses 001, 010, 100 in cycles 1, 7, 15; `done`=1 and `value`=-42 at cycle 19.
2. Mask 3'b010 → only layers 0 and 2 are started; `layer_start[1]` is never high.
3. Mask 3'b111 → `done`=1 at cycle 1, no `layer_start` pulse, `value` unchanged.
4. `abort` during WAIT on layer 1, then `layer_done[1]` one cycle later → IDLE, `done`=0, no further `layer_start`. A following `start` restarts from layer 0.
5. Stray `layer_done[2]` while waiting on layer 0, plus `layer_done[0]` high during ISSUE → both ignored; sequencing continues only on a valid `layer_done[0]` in WAIT.
6. With `CNN_SEQ_WATCHDOG_EN` and TIMEOUT_CYCLES=16, layer 1 never completes → `error`=1 and `layer_idx`=1. A subsequent `start` clears `error` and re-runs from layer 0.
